// File: rtl/fir_pkg.sv
// Shared constants, state encoding and small index helpers for the FIR MAC sequencer.
package fir_pkg;

    localparam int pDATA_WIDTH = 32;
    localparam int pADDR_WIDTH = 12;
    localparam int NUM_TAP     = 11;
    localparam int TAP_STRIDE  = 4;
    localparam int TAP_W       = $clog2(NUM_TAP + 1);
    localparam int IDX_W       = $clog2(NUM_TAP);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        PREFETCH,
        MAC,
        OUT
    } fir_state_e;

    // (head - k) mod NUM_TAP, both operands already in range
    function automatic logic [IDX_W-1:0] ring_idx(input logic [IDX_W-1:0] head,
                                                 input logic [TAP_W-1:0] k);
        int d;
        d = int'(head) - int'(k);
        if (d < 0) d = d + NUM_TAP;
        return IDX_W'(d);
    endfunction

    function automatic logic [TAP_W-1:0] clamp_taps(input logic [TAP_W-1:0] n);
        if (n == '0) return TAP_W'(1);
        if (int'(n) > NUM_TAP) return TAP_W'(NUM_TAP);
        return n;
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: one register per tap, synchronous clear, combinational read.
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter int DW    = pDATA_WIDTH,
    parameter int DEPTH = NUM_TAP,
    parameter int IW    = IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one FIR output per input sample: ring write, tap fetch, PE streaming, result hand-off.
//  state    | meaning
//  IDLE     | waiting for ap_start; cfg latched and ring cleared on start
//  WAIT_IN  | ss_tready high, waiting for the next sample
//  PREFETCH | tap RAM read of h[0] in flight
//  MAC      | one (x[n-k], h[k]) pair per cycle; extra clear cycle first when N == 1
//  OUT      | y[n] presented on the output stream until accepted
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic [TAP_W-1:0]       cfg_tap_num,
    input  logic [31:0]            cfg_data_len,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tready,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [pDATA_WIDTH-1:0] pe_mul_a,
    output logic [pDATA_WIDTH-1:0] pe_mul_b,
    output logic                   pe_cal,
    output logic                   pe_acc_on,
    output logic                   pe_last,
    input  logic [pDATA_WIDTH-1:0] pe_result,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
);

    fir_state_e             state, state_nxt;
    logic [TAP_W-1:0]       n_taps, k;
    logic [31:0]            data_len, cnt;
    logic [IDX_W-1:0]       head;
    logic                   clr_pend, done_r, k_last, run_end;
    logic [pDATA_WIDTH-1:0] y_r, rd_data;

    assign k_last  = !clr_pend && (k == n_taps - TAP_W'(1));
    assign run_end = (cnt + 32'd1 == data_len);

    fir_sample_ring u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == IDLE && ap_start),
        .wr_en   (state == WAIT_IN && ss_tvalid),
        .wr_idx  (head),
        .wr_data (ss_tdata),
        .rd_idx  (ring_idx(head, k)),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ap_start && cfg_data_len != '0) state_nxt = WAIT_IN;
            WAIT_IN:  if (ss_tvalid) state_nxt = PREFETCH;
            PREFETCH: state_nxt = MAC;
            MAC:      if (k_last) state_nxt = OUT;
            OUT:      if (sm_tready) state_nxt = run_end ? IDLE : WAIT_IN;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ap_idle   = 1'b0;
        ss_tready = 1'b0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        pe_mul_a  = '0;
        pe_mul_b  = '0;
        pe_cal    = 1'b0;
        pe_acc_on = 1'b0;
        pe_last   = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        case (state)
            IDLE:     ap_idle = 1'b1;
            WAIT_IN:  ss_tready = 1'b1;
            PREFETCH: tap_EN = 1'b1;
            MAC: begin
                pe_mul_a = rd_data;
                if (clr_pend) begin
                    // multiply by zero so the PE accumulator starts clean; keep h[0] read alive
                    tap_EN = 1'b1;
                    pe_cal = 1'b1;
                end else begin
                    pe_mul_b  = tap_Do;
                    tap_EN    = !k_last;
                    tap_A     = k_last ? '0 : pADDR_WIDTH'((int'(k) + 1) * TAP_STRIDE);
                    pe_cal    = !k_last;
                    pe_acc_on = k_last || (k != '0);
                    pe_last   = k_last;
                end
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = run_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_taps   <= TAP_W'(1);
            data_len <= '0;
            cnt      <= '0;
            head     <= '0;
            k        <= '0;
            clr_pend <= 1'b0;
            done_r   <= 1'b0;
            y_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (ap_start) begin
                    n_taps   <= clamp_taps(cfg_tap_num);
                    data_len <= cfg_data_len;
                    cnt      <= '0;
                    head     <= '0;
                    done_r   <= (cfg_data_len == '0);
                end
                PREFETCH: begin
                    k        <= '0;
                    clr_pend <= (n_taps == TAP_W'(1));
                end
                MAC: begin
                    if (clr_pend)     clr_pend <= 1'b0;
                    else if (!k_last) k <= k + TAP_W'(1);
                    if (k_last) y_r <= pe_result;
                end
                OUT: if (sm_tready) begin
                    head   <= (head == IDX_W'(NUM_TAP - 1)) ? '0 : head + IDX_W'(1);
                    cnt    <= cnt + 32'd1;
                    done_r <= run_end;
                end
                default: ;
            endcase
        end
    end

    assign ap_done  = done_r;
    assign sm_tdata = y_r;

endmodule
